// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART types and helpers: receiver state encoding,
//             oversampling ratio and the rounded baud-rate divisor.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    int den;
    den = baud * OVERSAMPLE;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. A push into a full
//             FIFO is accepted only when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver with 16x oversampling feeding a FWFT byte
//             FIFO, with sticky framing and overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rxd,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        framing_err,
  output logic                        overrun_err,
  input  logic                        clr_err
);

  localparam int            DIV      = baud_div(CLK_HZ, BAUD);
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]    TC_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    TC_LAST  = 4'(OVERSAMPLE - 1);

  logic            rxd_meta_q;
  logic            rxd_s_q;
  logic            rxd_prev_q;
  logic [DW-1:0]   div_q;
  rx_state_t       state_q;
  logic [3:0]      tc_q;
  logic [2:0]      bi_q;
  logic [7:0]      shift_q;
  logic            framing_err_q;
  logic            overrun_err_q;

  logic            tick;
  logic            start_edge;
  logic            stop_sample;
  logic            push;
  logic            frame_bad;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;

  assign tick        = (div_q == DIV_LAST);
  assign start_edge  = (state_q == IDLE) && rxd_prev_q && !rxd_s_q;
  assign stop_sample = (state_q == STOP) && tick && (tc_q == TC_LAST);
  assign push        = stop_sample && rxd_s_q;
  assign frame_bad   = stop_sample && !rxd_s_q;
  // Full implies non-empty, so rd_ready alone means the pop really happens.
  assign drop        = push && fifo_full && !rd_ready;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  // Oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (start_edge || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Deframing FSM: validate start at mid-bit, shift data LSB-first, check stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tc_q    <= '0;
      bi_q    <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            tc_q    <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tc_q == TC_MID) begin
              if (!rxd_s_q) begin
                tc_q    <= '0;
                bi_q    <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tc_q <= tc_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tc_q == TC_LAST) begin
              shift_q <= {rxd_s_q, shift_q[7:1]};
              bi_q    <= bi_q + 3'd1;
              tc_q    <= '0;
              if (bi_q == 3'd7) state_q <= STOP;
            end else begin
              tc_q <= tc_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            // Leave at mid-stop-bit so the next start edge is not missed.
            if (tc_q == TC_LAST) state_q <= IDLE;
            else                 tc_q    <= tc_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (frame_bad)    framing_err_q <= 1'b1;
      else if (clr_err) framing_err_q <= 1'b0;
      if (drop)         overrun_err_q <= 1'b1;
      else if (clr_err) overrun_err_q <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_ready),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

  assign rd_valid    = !fifo_empty;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo with a queue-based
//             reference model of the receive buffer and error flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  // Line rate scaled up so one bit is 64 clocks (divisor 4).
  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 781_250;
  localparam int DEPTH    = 8;
  localparam int BIT      = CLK_HZ / BAUD;
  localparam int FRAME    = 10 * BIT;
  // Stop bit sampled 9.5 bit times after the start edge, plus 3 clocks of
  // synchroniser / edge-detect delay; the byte is visible one clock later.
  localparam int PUSH_LAT = 3 + (19 * BIT) / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [3:0] rx_count;
  logic       framing_err;
  logic       overrun_err;
  logic       clr_err = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: received bytes in order plus sticky flags.
  logic [7:0] mq[$];
  logic       m_fe;
  logic       m_oe;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rx_count    (rx_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_fe = 1'b0;
    m_oe = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)               m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        m_oe = 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input int period, input bit stop_bit);
    rxd = 1'b0;
    clk_n(period);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      clk_n(period);
    end
    rxd = stop_bit;
    clk_n(period);
    rxd = 1'b1;
    if (!stop_bit) clk_n(period);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    clk_n(1);
    rd_ready = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic dut_reset();
    rxd = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
    reset_n = 1'b0;
    clk_n(2);
    reset_n = 1'b1;
    clk_n(2);
    model_reset();
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rxd = 1'b1;
    reset_n = 1'b0;
    clk_n(3);
    n_chk++;
    if ({rd_valid, rd_data, rx_count, framing_err, overrun_err} !== 15'd0)
      $display("FAIL reset_hold: got v=%0b d=%h c=%0d fe=%0b oe=%0b want all 0",
               rd_valid, rd_data, rx_count, framing_err, overrun_err);
    else n_pass++;
    reset_n = 1'b1;
    clk_n(2000);
    model_reset();
    n_chk++;
    if ({rd_valid, rd_data, rx_count, framing_err, overrun_err} !== 15'd0)
      $display("FAIL reset_idle: got v=%0b d=%h c=%0d fe=%0b oe=%0b want all 0",
               rd_valid, rd_data, rx_count, framing_err, overrun_err);
    else n_pass++;
    b = 8'($urandom);
    send_frame(b, BIT, 1'b1);
    model_frame(b, 1'b1);
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== mq[0])
      $display("FAIL reset_prefill: got v=%0b d=%h want v=1 d=%h", rd_valid, rd_data, mq[0]);
    else n_pass++;
    fork
      send_frame(8'hFF, BIT, 1'b1);
      begin
        clk_n(3 * BIT);
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (rd_valid !== 1'b0 || rx_count !== 4'd0)
          $display("FAIL reset_midframe: got v=%0b c=%0d want v=0 c=0", rd_valid, rx_count);
        else n_pass++;
        clk_n(2 * BIT);
        reset_n = 1'b1;
      end
    join
    model_reset();
    clk_n(2 * FRAME);
    n_chk++;
    if (rd_valid !== 1'b0 || rx_count !== 4'd0 || framing_err !== 1'b0 || overrun_err !== 1'b0)
      $display("FAIL reset_after: got v=%0b c=%0d fe=%0b oe=%0b want all 0",
               rd_valid, rx_count, framing_err, overrun_err);
    else n_pass++;
  endtask

  task automatic test_single();
    dut_reset();
    fork
      send_frame(8'hA5, BIT, 1'b1);
      begin
        clk_n(PUSH_LAT - 1);
        n_chk++;
        if (rd_valid !== 1'b0)
          $display("FAIL single_early: got v=%0b want 0", rd_valid);
        else n_pass++;
        clk_n(1);
        n_chk++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rx_count !== 4'd1)
          $display("FAIL single_byte: got v=%0b d=%h c=%0d want v=1 d=a5 c=1",
                   rd_valid, rd_data, rx_count);
        else n_pass++;
      end
    join
    model_frame(8'hA5, 1'b1);
    pop_one();
    n_chk++;
    if (rd_valid !== 1'b0 || rx_count !== 4'd0)
      $display("FAIL single_pop: got v=%0b c=%0d want v=0 c=0", rd_valid, rx_count);
    else n_pass++;
  endtask

  task automatic test_glitch_baud();
    logic [7:0] bytes [3];
    int         per   [3];
    dut_reset();
    rxd = 1'b0;
    clk_n(15);
    rxd = 1'b1;
    clk_n(2 * FRAME);
    n_chk++;
    if (rx_count !== 4'd0 || framing_err !== 1'b0 || overrun_err !== 1'b0)
      $display("FAIL glitch: got c=%0d fe=%0b oe=%0b want 0 0 0", rx_count, framing_err, overrun_err);
    else n_pass++;
    bytes = '{8'h00, 8'hFF, 8'h55};
    per   = '{BIT + 2, BIT - 2, BIT + 2};
    for (int i = 0; i < 3; i++) begin
      send_frame(bytes[i], per[i], 1'b1);
      model_frame(bytes[i], 1'b1);
    end
    n_chk++;
    if (rx_count !== 4'(mq.size()) || framing_err !== m_fe || overrun_err !== m_oe)
      $display("FAIL skew_count: got c=%0d fe=%0b oe=%0b want c=%0d fe=%0b oe=%0b",
               rx_count, framing_err, overrun_err, mq.size(), m_fe, m_oe);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== mq[0])
        $display("FAIL skew_data%0d: got v=%0b d=%h want v=1 d=%h", i, rd_valid, rd_data, mq[0]);
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_framing();
    dut_reset();
    send_frame(8'h3C, BIT, 1'b0);
    model_frame(8'h3C, 1'b0);
    n_chk++;
    if (rx_count !== 4'(mq.size()) || framing_err !== m_fe)
      $display("FAIL framing_stop: got c=%0d fe=%0b want c=%0d fe=%0b",
               rx_count, framing_err, mq.size(), m_fe);
    else n_pass++;
    rxd = 1'b0;
    clk_n(2 * FRAME);
    rxd = 1'b1;
    clk_n(2 * FRAME);
    n_chk++;
    if (framing_err !== 1'b1 || rd_valid !== 1'b0 || rx_count !== 4'd0)
      $display("FAIL framing_break: got fe=%0b v=%0b c=%0d want fe=1 v=0 c=0",
               framing_err, rd_valid, rx_count);
    else n_pass++;
    clr_err = 1'b1;
    clk_n(1);
    clr_err = 1'b0;
    m_fe = 1'b0;
    n_chk++;
    if (framing_err !== m_fe)
      $display("FAIL framing_clear: got fe=%0b want %0b", framing_err, m_fe);
    else n_pass++;
  endtask

  task automatic test_overrun();
    dut_reset();
    for (int i = 1; i <= 10; i++) begin
      send_frame(8'(i), BIT, 1'b1);
      model_frame(8'(i), 1'b1);
    end
    n_chk++;
    if (rx_count !== 4'(mq.size()) || overrun_err !== m_oe)
      $display("FAIL overrun_fill: got c=%0d oe=%0b want c=%0d oe=%0b",
               rx_count, overrun_err, mq.size(), m_oe);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== mq[0])
        $display("FAIL overrun_drain%0d: got v=%0b d=%h want v=1 d=%h", i, rd_valid, rd_data, mq[0]);
      else n_pass++;
      pop_one();
    end
    dut_reset();
    fork
      for (int i = 1; i <= 9; i++) send_frame(8'(i), BIT, 1'b1);
      begin
        clk_n(8 * FRAME + PUSH_LAT - 1);
        rd_ready = 1'b1;
        clk_n(1);
        rd_ready = 1'b0;
      end
    join
    for (int i = 1; i <= 8; i++) model_frame(8'(i), 1'b1);
    void'(mq.pop_front());
    model_frame(8'd9, 1'b1);
    n_chk++;
    if (rx_count !== 4'(mq.size()) || overrun_err !== m_oe)
      $display("FAIL overrun_pop_push: got c=%0d oe=%0b want c=%0d oe=%0b",
               rx_count, overrun_err, mq.size(), m_oe);
    else n_pass++;
    while (mq.size() > 0) begin
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== mq[0])
        $display("FAIL overrun_order: got v=%0b d=%h want v=1 d=%h", rd_valid, rd_data, mq[0]);
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_err_priority();
    logic [7:0] b [9];
    dut_reset();
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    fork
      for (int i = 0; i < 9; i++) send_frame(b[i], BIT, 1'b1);
      begin
        clk_n(8 * FRAME + PUSH_LAT - 1);
        clr_err = 1'b1;
        clk_n(1);
        n_chk++;
        if (overrun_err !== 1'b1)
          $display("FAIL prio_set_wins: got oe=%0b want 1", overrun_err);
        else n_pass++;
        clk_n(1);
        clr_err = 1'b0;
        n_chk++;
        if (overrun_err !== 1'b0)
          $display("FAIL prio_clear: got oe=%0b want 0", overrun_err);
        else n_pass++;
      end
    join
    n_chk++;
    if (rx_count !== 4'(DEPTH) || rd_data !== b[0])
      $display("FAIL prio_contents: got c=%0d d=%h want c=%0d d=%h", rx_count, rd_data, DEPTH, b[0]);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    bit         ok;
    int         per;
    dut_reset();
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      per = BIT - 2 + int'($urandom_range(0, 4));
      send_frame(b, per, ok);
      model_frame(b, ok);
      n_chk++;
      if (rx_count !== 4'(mq.size()) || framing_err !== m_fe || overrun_err !== m_oe ||
          rd_valid !== (mq.size() > 0) || (mq.size() > 0 && rd_data !== mq[0]))
        $display("FAIL rand_frame%0d: got c=%0d v=%0b d=%h fe=%0b oe=%0b want c=%0d fe=%0b oe=%0b",
                 k, rx_count, rd_valid, rd_data, framing_err, overrun_err, mq.size(), m_fe, m_oe);
      else n_pass++;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) pop_one();
      end
    end
    while (mq.size() > 0) begin
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== mq[0])
        $display("FAIL rand_drain: got v=%0b d=%h want v=1 d=%h", rd_valid, rd_data, mq[0]);
      else n_pass++;
      pop_one();
    end
    n_chk++;
    if (rd_valid !== 1'b0 || rx_count !== 4'd0)
      $display("FAIL rand_empty: got v=%0b c=%0d want v=0 c=0", rd_valid, rx_count);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_glitch_baud();
    test_framing();
    test_overrun();
    test_err_priority();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
